// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of a single-port SRAM macro: port A has fixed priority,
// port B is promoted after MaxWait stalled cycles and is blocked entirely while lock_i is set.
module sram_port_arbiter #(
    parameter int unsigned AW      = 11,
    parameter int unsigned DW      = 32,
    parameter int unsigned MaxWait = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              lock_i,

    input  logic              a_req_i,
    input  logic              a_we_i,
    input  logic [AW-1:0]     a_addr_i,
    input  logic [DW-1:0]     a_wdata_i,
    input  logic [DW/8-1:0]   a_wmask_i,
    output logic              a_gnt_o,
    output logic              a_rvalid_o,
    output logic [DW-1:0]     a_rdata_o,

    input  logic              b_req_i,
    input  logic              b_we_i,
    input  logic [AW-1:0]     b_addr_i,
    input  logic [DW-1:0]     b_wdata_i,
    input  logic [DW/8-1:0]   b_wmask_i,
    output logic              b_gnt_o,
    output logic              b_rvalid_o,
    output logic [DW-1:0]     b_rdata_o,

    output logic              sram_csb_o,
    output logic              sram_web_o,
    output logic [DW/8-1:0]   sram_wmask_o,
    output logic [AW-1:0]     sram_addr_o,
    output logic [DW-1:0]     sram_wdata_o,
    input  logic [DW-1:0]     sram_rdata_i
);

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    localparam logic [3:0] MaxWaitW = 4'(MaxWait);

    logic [3:0] wait_q, wait_d;
    logic       pend_q;
    owner_e     owner_q;
    logic       rd_q;

    logic       promote;
    logic       a_win, b_win;

    // Grants are suppressed while reset is asserted so the SRAM sees an idle bus.
    always_comb begin
        promote = (wait_q == MaxWaitW) && !lock_i;
        b_win   = rst_ni && b_req_i && !lock_i && (promote || !a_req_i);
        a_win   = rst_ni && a_req_i && !b_win;
        a_gnt_o = a_win;
        b_gnt_o = b_win;
    end

    always_comb begin
        sram_csb_o   = 1'b1;
        sram_web_o   = 1'b1;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_wmask_o = '0;
        if (b_win) begin
            sram_csb_o   = 1'b0;
            sram_web_o   = ~b_we_i;
            sram_addr_o  = b_addr_i;
            sram_wdata_o = b_wdata_i;
            sram_wmask_o = b_wmask_i;
        end else if (a_win) begin
            sram_csb_o   = 1'b0;
            sram_web_o   = ~a_we_i;
            sram_addr_o  = a_addr_i;
            sram_wdata_o = a_wdata_i;
            sram_wmask_o = a_wmask_i;
        end
    end

    always_comb begin
        wait_d = '0;
        if (b_req_i && !b_win && !lock_i) begin
            wait_d = (wait_q == MaxWaitW) ? wait_q : wait_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q  <= '0;
            pend_q  <= 1'b0;
            owner_q <= OWN_A;
            rd_q    <= 1'b0;
        end else begin
            wait_q <= wait_d;
            pend_q <= a_win || b_win;
            if (b_win) begin
                owner_q <= OWN_B;
                rd_q    <= ~b_we_i;
            end else if (a_win) begin
                owner_q <= OWN_A;
                rd_q    <= ~a_we_i;
            end
        end
    end

    // Writes still get an rvalid, but their rdata is forced to zero.
    always_comb begin
        a_rvalid_o = pend_q && (owner_q == OWN_A);
        b_rvalid_o = pend_q && (owner_q == OWN_B);
        a_rdata_o  = (a_rvalid_o && rd_q) ? sram_rdata_i : '0;
        b_rdata_o  = (b_rvalid_o && rd_q) ? sram_rdata_i : '0;
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: table-driven vectors plus hand sequences, a behavioural
// SRAM on the macro pins, and a response scoreboard fed from a shadow memory.
module tb_sram_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        lock_i;
    logic        a_req_i, a_we_i, b_req_i, b_we_i;
    logic [10:0] a_addr_i, b_addr_i;
    logic [31:0] a_wdata_i, b_wdata_i;
    logic [3:0]  a_wmask_i, b_wmask_i;
    logic        a_gnt_o, a_rvalid_o, b_gnt_o, b_rvalid_o;
    logic [31:0] a_rdata_o, b_rdata_o;
    logic        sram_csb_o, sram_web_o;
    logic [3:0]  sram_wmask_o;
    logic [10:0] sram_addr_o;
    logic [31:0] sram_wdata_o;
    logic [31:0] sram_rdata_i;

    sram_port_arbiter #(.AW(11), .DW(32), .MaxWait(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .lock_i(lock_i),
        .a_req_i(a_req_i), .a_we_i(a_we_i), .a_addr_i(a_addr_i),
        .a_wdata_i(a_wdata_i), .a_wmask_i(a_wmask_i),
        .a_gnt_o(a_gnt_o), .a_rvalid_o(a_rvalid_o), .a_rdata_o(a_rdata_o),
        .b_req_i(b_req_i), .b_we_i(b_we_i), .b_addr_i(b_addr_i),
        .b_wdata_i(b_wdata_i), .b_wmask_i(b_wmask_i),
        .b_gnt_o(b_gnt_o), .b_rvalid_o(b_rvalid_o), .b_rdata_o(b_rdata_o),
        .sram_csb_o(sram_csb_o), .sram_web_o(sram_web_o), .sram_wmask_o(sram_wmask_o),
        .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural macro: one-cycle read latency, byte-masked writes.
    logic [31:0] mem [2048];
    always @(posedge clk_i) begin
        if (!sram_csb_o) begin
            if (!sram_web_o) begin
                for (int k = 0; k < 4; k++)
                    if (sram_wmask_o[k]) mem[sram_addr_o][8*k +: 8] <= sram_wdata_o[8*k +: 8];
            end else begin
                sram_rdata_i <= mem[sram_addr_o];
            end
        end
    end

    typedef struct {
        logic        lock;
        logic        a_req, a_we;
        logic [10:0] a_addr;
        logic [31:0] a_wdata;
        logic [3:0]  a_wmask;
        logic        b_req, b_we;
        logic [10:0] b_addr;
        logic [31:0] b_wdata;
        logic [3:0]  b_wmask;
        logic        exp_a_gnt, exp_b_gnt;
    } vec_t;

    typedef struct {
        int          due;
        logic        port_b;
        logic [31:0] data;
    } resp_t;

    resp_t       sb[$];
    logic [31:0] shadow [2048];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=0x%08h required=0x%08h", name, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic lock,
                                input logic a_req, input logic a_we, input logic [10:0] a_addr,
                                input logic [31:0] a_wdata, input logic [3:0] a_wmask,
                                input logic b_req, input logic b_we, input logic [10:0] b_addr,
                                input logic [31:0] b_wdata, input logic [3:0] b_wmask,
                                input logic ea, input logic eb);
        vec_t v;
        v.lock = lock;
        v.a_req = a_req; v.a_we = a_we; v.a_addr = a_addr; v.a_wdata = a_wdata; v.a_wmask = a_wmask;
        v.b_req = b_req; v.b_we = b_we; v.b_addr = b_addr; v.b_wdata = b_wdata; v.b_wmask = b_wmask;
        v.exp_a_gnt = ea; v.exp_b_gnt = eb;
        return v;
    endfunction

    task automatic check_resp();
        logic        ev_a, ev_b;
        logic [31:0] ed_a, ed_b;
        resp_t       e;
        ev_a = 1'b0; ev_b = 1'b0; ed_a = '0; ed_b = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if (e.port_b) begin ev_b = 1'b1; ed_b = e.data; end
            else          begin ev_a = 1'b1; ed_a = e.data; end
        end
        chk("a_rvalid", {31'b0, a_rvalid_o}, {31'b0, ev_a});
        chk("b_rvalid", {31'b0, b_rvalid_o}, {31'b0, ev_b});
        chk("a_rdata", a_rdata_o, ed_a);
        chk("b_rdata", b_rdata_o, ed_b);
    endtask

    task automatic step(input vec_t v);
        logic        e_csb, e_web, w_we;
        logic [10:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wmask;
        resp_t       r;
        @(posedge clk_i); #1;
        lock_i = v.lock;
        a_req_i = v.a_req; a_we_i = v.a_we; a_addr_i = v.a_addr; a_wdata_i = v.a_wdata; a_wmask_i = v.a_wmask;
        b_req_i = v.b_req; b_we_i = v.b_we; b_addr_i = v.b_addr; b_wdata_i = v.b_wdata; b_wmask_i = v.b_wmask;
        @(negedge clk_i);
        chk("a_gnt", {31'b0, a_gnt_o}, {31'b0, v.exp_a_gnt});
        chk("b_gnt", {31'b0, b_gnt_o}, {31'b0, v.exp_b_gnt});
        e_csb = 1'b1; e_web = 1'b1; e_addr = '0; e_wdata = '0; e_wmask = '0; w_we = 1'b0;
        if (v.exp_b_gnt) begin
            e_csb = 1'b0; w_we = v.b_we; e_web = ~v.b_we;
            e_addr = v.b_addr; e_wdata = v.b_wdata; e_wmask = v.b_wmask;
        end else if (v.exp_a_gnt) begin
            e_csb = 1'b0; w_we = v.a_we; e_web = ~v.a_we;
            e_addr = v.a_addr; e_wdata = v.a_wdata; e_wmask = v.a_wmask;
        end
        chk("sram_csb", {31'b0, sram_csb_o}, {31'b0, e_csb});
        chk("sram_web", {31'b0, sram_web_o}, {31'b0, e_web});
        chk("sram_addr", {21'b0, sram_addr_o}, {21'b0, e_addr});
        chk("sram_wdata", sram_wdata_o, e_wdata);
        chk("sram_wmask", {28'b0, sram_wmask_o}, {28'b0, e_wmask});
        check_resp();
        if (!e_csb) begin
            r.due = cyc + 1;
            r.port_b = v.exp_b_gnt;
            r.data = w_we ? 32'h0 : shadow[e_addr];
            if (w_we)
                for (int k = 0; k < 4; k++)
                    if (e_wmask[k]) shadow[e_addr][8*k +: 8] = e_wdata[8*k +: 8];
            sb.push_back(r);
        end
        cyc++;
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem[i] = '0;
            shadow[i] = '0;
        end
        sram_rdata_i = '0;
        rst_ni = 1'b0; lock_i = 1'b0;
        a_req_i = 1'b0; a_we_i = 1'b0; a_addr_i = '0; a_wdata_i = '0; a_wmask_i = '0;
        b_req_i = 1'b0; b_we_i = 1'b0; b_addr_i = '0; b_wdata_i = '0; b_wmask_i = '0;

        @(negedge clk_i);
        chk("rst_a_gnt", {31'b0, a_gnt_o}, 32'h0);
        chk("rst_b_gnt", {31'b0, b_gnt_o}, 32'h0);
        chk("rst_a_rvalid", {31'b0, a_rvalid_o}, 32'h0);
        chk("rst_b_rvalid", {31'b0, b_rvalid_o}, 32'h0);
        chk("rst_a_rdata", a_rdata_o, 32'h0);
        chk("rst_b_rdata", b_rdata_o, 32'h0);
        chk("rst_csb", {31'b0, sram_csb_o}, 32'h1);
        chk("rst_web", {31'b0, sram_web_o}, 32'h1);
        chk("rst_addr", {21'b0, sram_addr_o}, 32'h0);
        chk("rst_wait", {28'b0, dut.wait_q}, 32'h0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        //         lock a_req we addr     wdata         mask  b_req we addr     wdata         mask  ea eb
        tbl.push_back(mk(0, 1, 1, 11'h010, 32'hDEADBEEF, 4'hF, 0, 0, 11'h000, 32'h0,        4'h0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 11'h000, 32'h0,        4'h0, 1, 0, 11'h010, 32'h0,        4'h0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 11'h000, 32'h0,        4'h0, 1, 1, 11'h7FF, 32'h0000ABCD, 4'h3, 0, 1));
        tbl.push_back(mk(0, 0, 0, 11'h000, 32'h0,        4'h0, 1, 0, 11'h7FF, 32'h0,        4'h0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 11'h010, 32'h0,        4'h0, 1, 0, 11'h7FF, 32'h0,        4'h0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 11'h000, 32'h0,        4'h0, 0, 0, 11'h000, 32'h0,        4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 11'h020, 32'h11223344, 4'h5, 0, 0, 11'h000, 32'h0,        4'h0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 11'h020, 32'h0,        4'h0, 0, 0, 11'h000, 32'h0,        4'h0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 11'h010, 32'h0,        4'h0, 1, 0, 11'h010, 32'h0,        4'h0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 11'h000, 32'h0,        4'h0, 1, 0, 11'h010, 32'h0,        4'h0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 11'h000, 32'h0,        4'h0, 1, 0, 11'h7FF, 32'h0,        4'h0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 11'h000, 32'h0,        4'h0, 1, 0, 11'h7FF, 32'h0,        4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 11'h010, 32'h0,        4'h0, 0, 0, 11'h000, 32'h0,        4'h0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 11'h000, 32'h0,        4'h0, 1, 0, 11'h7FF, 32'h0,        4'h0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 11'h020, 32'h0,        4'h0, 0, 0, 11'h000, 32'h0,        4'h0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 11'h000, 32'h0,        4'h0, 1, 0, 11'h010, 32'h0,        4'h0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 11'h000, 32'h0,        4'h0, 0, 0, 11'h000, 32'h0,        4'h0, 0, 0));
        foreach (tbl[i]) step(tbl[i]);

        // Both ports saturate the bus: A,A,A,A,B repeating with wait_q tracking 0..4.
        for (int i = 0; i < 20; i++) begin
            v = mk(0, 1, 0, 11'h010, 32'h0, 4'h0, 1, 0, 11'h7FF, 32'h0, 4'h0,
                   (i % 5) != 4, (i % 5) == 4);
            step(v);
            chk("starve_wait", {28'b0, dut.wait_q}, i % 5);
        end

        // Locked: B requests for 20 cycles and is never served.
        for (int i = 0; i < 20; i++) begin
            v = mk(1, 0, 0, 11'h000, 32'h0, 4'h0, 1, 0, 11'h010, 32'h0, 4'h0, 0, 0);
            step(v);
            chk("lock_wait", {28'b0, dut.wait_q}, 32'h0);
        end

        // Reset in the cycle after an A read grant drops the response.
        step(mk(0, 1, 0, 11'h010, 32'h0, 4'h0, 0, 0, 11'h000, 32'h0, 4'h0, 1, 0));
        @(posedge clk_i); #1;
        rst_ni = 1'b0; lock_i = 1'b0; a_req_i = 1'b0; b_req_i = 1'b0;
        @(negedge clk_i);
        chk("mid_rst_a_rvalid", {31'b0, a_rvalid_o}, 32'h0);
        chk("mid_rst_b_rvalid", {31'b0, b_rvalid_o}, 32'h0);
        chk("mid_rst_a_rdata", a_rdata_o, 32'h0);
        chk("mid_rst_csb", {31'b0, sram_csb_o}, 32'h1);
        sb.delete();
        cyc++;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        cyc++;
        for (int i = 0; i < 3; i++)
            step(mk(0, 0, 0, 11'h000, 32'h0, 4'h0, 0, 0, 11'h000, 32'h0, 4'h0, 0, 0));

        // Data written before reset is still in the macro.
        step(mk(0, 0, 0, 11'h000, 32'h0, 4'h0, 1, 0, 11'h020, 32'h0, 4'h0, 0, 1));
        step(mk(0, 0, 0, 11'h000, 32'h0, 4'h0, 0, 0, 11'h000, 32'h0, 4'h0, 0, 0));
        chk("sb_drained", sb.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
